// File: rtl/lapido_fetch_queue.sv
// lapido_fetch_queue: instruction fetch front end with a prefetch queue and redirect flush
module lapido_fetch_queue #(
    parameter int                   PC_WIDTH = 10,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
    parameter int                   DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        imem_req,
    output logic [PC_WIDTH-1:0]         imem_addr,
    input  logic [31:0]                 imem_rdata,
    input  logic                        is_jump,
    input  logic [PC_WIDTH-1:0]         jump_addr,
    input  logic                        branch_taken,
    input  logic [PC_WIDTH-1:0]         branch_addr,
    input  logic                        id_stall,
    output logic                        instr_valid,
    output logic [31:0]                 instruction,
    output logic [PC_WIDTH-1:0]         next_pc,
    output logic [$clog2(DEPTH):0]      queue_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d, tag_q, tag_d;
    logic                inflight_q, inflight_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [31:0]         instr_q [DEPTH];
    logic [PC_WIDTH-1:0] npc_q [DEPTH];
    logic                redirect, push, pop;
    logic [PC_WIDTH-1:0] target;

    assign redirect    = is_jump | branch_taken;
    assign target      = is_jump ? jump_addr : branch_addr;
    assign imem_req    = rst & ~redirect & (({1'b0, count_q} + (CW+1)'(inflight_q)) < (CW+1)'(DEPTH));
    assign imem_addr   = fetch_pc_q;
    assign push        = rst & inflight_q & ~redirect;
    assign instr_valid = count_q != '0;
    assign pop         = instr_valid & ~id_stall;
    assign instruction = instr_valid ? instr_q[rd_ptr_q] : '0;
    assign next_pc     = instr_valid ? npc_q[rd_ptr_q] : '0;
    assign queue_count = count_q;

    // next-state: redirect flushes the queue and retargets fetch, otherwise issue/push/pop
    always_comb begin
        fetch_pc_d = redirect ? target : imem_req ? fetch_pc_q + PC_WIDTH'(1) : fetch_pc_q;
        tag_d      = imem_req ? fetch_pc_q : tag_q;
        inflight_d = imem_req;
        rd_ptr_d   = redirect ? '0 : rd_ptr_q + AW'(pop);
        wr_ptr_d   = redirect ? '0 : wr_ptr_q + AW'(push);
        count_d    = redirect ? '0 : count_q + CW'(push) - CW'(pop);
    end

    // control state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // queue storage; the returned word is tagged with the PC following its fetch address
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr_q] <= imem_rdata;
            npc_q[wr_ptr_q]   <= tag_q + PC_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_lapido_fetch_queue.sv
// tb_lapido_fetch_queue: randomized and directed checks of the fetch queue against a queue-based model
module tb_lapido_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, is_jump, branch_taken, id_stall;
    logic [9:0]  jump_addr, branch_addr;
    logic        imem_req, instr_valid;
    logic [9:0]  imem_addr, next_pc;
    logic [31:0] imem_rdata, instruction;
    logic [2:0]  queue_count;

    int compared = 0;
    int mismatched = 0;

    int mq[$];
    int mpc = 0;
    int mtag = 0;
    bit minf = 0;

    logic [56:0] got, exp;

    lapido_fetch_queue #(.PC_WIDTH(10), .RESET_PC(10'd0), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .is_jump(is_jump), .jump_addr(jump_addr),
        .branch_taken(branch_taken), .branch_addr(branch_addr), .id_stall(id_stall),
        .instr_valid(instr_valid), .instruction(instruction), .next_pc(next_pc),
        .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        imem_rdata <= imem_req ? (32'hA000_0000 | 32'(imem_addr)) : $urandom;

    assign got = {imem_req, imem_addr, instr_valid, instruction, next_pc, queue_count};

    function automatic logic [56:0] model_out();
        logic        v, req;
        logic [31:0] ins;
        logic [9:0]  np;
        v   = mq.size() != 0;
        ins = v ? (32'hA000_0000 | 32'(mq[0])) : 32'h0;
        np  = v ? 10'(mq[0] + 1) : 10'h0;
        req = rst && !(is_jump || branch_taken) && (mq.size() + int'(minf) < DEPTH);
        return {req, 10'(mpc), v, ins, np, 3'(mq.size())};
    endfunction

    task automatic drive(input logic r, input logic j, input int ja, input logic b, input int ba, input logic st);
        rst = r; is_jump = j; jump_addr = 10'(ja); branch_taken = b; branch_addr = 10'(ba); id_stall = st;
        #0;
    endtask

    task automatic advance();
        int  sz;
        bit  req;
        sz = mq.size();
        if (!rst) begin
            mq.delete(); mpc = 0; minf = 0;
        end else if (is_jump || branch_taken) begin
            mq.delete(); mpc = is_jump ? int'(jump_addr) : int'(branch_addr); minf = 0;
        end else begin
            req = sz + int'(minf) < DEPTH;
            if (sz > 0 && !id_stall) void'(mq.pop_front());
            if (minf) mq.push_back(mtag);
            if (req) begin mtag = mpc; mpc = (mpc + 1) % 1024; minf = 1; end
            else minf = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0);
        advance();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            compared++;
            if (got !== {1'b0, 10'h0, 1'b0, 32'h0, 10'h0, 3'h0}) begin
                mismatched++;
                $display("FAIL reset cyc %0d got %h exp all-zero", i, got);
            end
            advance();
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 14; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            exp = model_out();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL stream cyc %0d got %h exp %h", i, got, exp);
            end
            if (i == 2) begin
                compared++;
                if ({instr_valid, instruction, next_pc} !== {1'b1, 32'hA000_0000, 10'd1}) begin
                    mismatched++;
                    $display("FAIL stream_first got %b %h %h exp 1 a0000000 001", instr_valid, instruction, next_pc);
                end
            end
            advance();
        end
    endtask

    task automatic test_stall();
        drive(0, 0, 0, 0, 0, 1);
        advance();
        for (int i = 0; i < 18; i++) begin
            drive(1, 0, 0, 0, 0, i < 9);
            exp = model_out();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL stall cyc %0d got %h exp %h", i, got, exp);
            end
            if (i == 8) begin
                compared++;
                if ({queue_count, imem_req, instruction} !== {3'd4, 1'b0, 32'hA000_0000}) begin
                    mismatched++;
                    $display("FAIL stall_full got cnt %0d req %b ins %h exp 4 0 a0000000", queue_count, imem_req, instruction);
                end
            end
            advance();
        end
    endtask

    task automatic test_jump();
        int guard = 0;
        drive(0, 0, 0, 0, 0, 1);
        advance();
        while (!(mq.size() == 3 && minf) && guard < 20) begin
            drive(1, 0, 0, 0, 0, 1);
            advance();
            guard++;
        end
        for (int i = 0; i < 6; i++) begin
            drive(1, i == 0, 'h100, 0, 0, 0);
            exp = model_out();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL jump cyc %0d got %h exp %h", i, got, exp);
            end
            if (i == 3) begin
                compared++;
                if ({instruction, next_pc} !== {32'hA000_0100, 10'h101}) begin
                    mismatched++;
                    $display("FAIL jump_target got %h %h exp a0000100 101", instruction, next_pc);
                end
            end
            advance();
        end
    endtask

    task automatic test_both();
        for (int i = 0; i < 8; i++) begin
            drive(1, i == 0, 'h20, i == 0, 'h40, 0);
            exp = model_out();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL both cyc %0d got %h exp %h", i, got, exp);
            end
            if (i == 3) begin
                compared++;
                if (instruction !== 32'hA000_0020) begin
                    mismatched++;
                    $display("FAIL both_target got %h exp a0000020", instruction);
                end
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 7; i++) begin
            drive(1, i == 0, 'h3FF, 0, 0, 0);
            exp = model_out();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL wrap cyc %0d got %h exp %h", i, got, exp);
            end
            if (i == 3) begin
                compared++;
                if ({instruction, next_pc} !== {32'hA000_03FF, 10'h000}) begin
                    mismatched++;
                    $display("FAIL wrap_entry got %h %h exp a00003ff 000", instruction, next_pc);
                end
            end
            if (i == 4) begin
                compared++;
                if ({instruction, next_pc} !== {32'hA000_0000, 10'h001}) begin
                    mismatched++;
                    $display("FAIL wrap_next got %h %h exp a0000000 001", instruction, next_pc);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 0, 0, 1);
            advance();
        end
        drive(0, 0, 0, 0, 0, 1);
        advance();
        drive(1, 0, 0, 0, 0, 0);
        compared++;
        if ({imem_addr, instr_valid, instruction, next_pc, queue_count} !== 56'h0) begin
            mismatched++;
            $display("FAIL reset_mid got addr %h v %b ins %h np %h cnt %0d exp all-zero", imem_addr, instr_valid, instruction, next_pc, queue_count);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            exp = model_out();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL reset_mid cyc %0d got %h exp %h", i, got, exp);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(63) != 0, $urandom_range(15) == 0, $urandom_range(1023),
                  $urandom_range(15) == 0, $urandom_range(1023), $urandom_range(2) == 0);
            exp = model_out();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL random cyc %0d got %h exp %h", i, got, exp);
            end
            advance();
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        test_reset();
        test_stream();
        test_stall();
        test_jump();
        test_both();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/lapido_fetch_queue.md
Name: lapido_fetch_queue

Overview:
- Instruction-fetch front end of the LAPI DOpaCA pipeline.
- Owns the fetch PC and drives a synchronous instruction memory (1-cycle read latency).
- Buffers returned words in a small prefetch queue and presents them, with their PC+1, to the decode stage under a valid/stall handshake.
- Consumes the jump/branch redirect produced by the write-back stage and flushes all wrong-path fetches.

Parameters:
- PC_WIDTH, 10, width of word-addressed PC; wraps modulo 2^PC_WIDTH.
- RESET_PC, 0, first fetch address after reset.
- DEPTH, 4, prefetch queue entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (rst=0 resets on the clock edge).
- imem_req  output  1  read request to instruction memory this cycle.
- imem_addr  output  PC_WIDTH  word address of the request (= fetch_pc).
- imem_rdata  input  32  instruction word; valid the cycle after a request.
- is_jump  input  1  unconditional jump redirect from WB.
- jump_addr  input  PC_WIDTH  jump target.
- branch_taken  input  1  taken PC-relative branch redirect from WB.
- branch_addr  input  PC_WIDTH  branch target.
- id_stall  input  1  decode cannot accept this cycle.
- instr_valid  output  1  instruction/next_pc hold a valid entry.
- instruction  output  32  queue head instruction; 0 when empty.
- next_pc  output  PC_WIDTH  PC of queue head + 1 (mod 2^PC_WIDTH); 0 when empty.
- queue_count  output  log2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (rst=0 at an edge):
  - fetch_pc<=RESET_PC; queue empty; pointers 0; inflight<=0.
  - Outputs: instr_valid=0, instruction=0, next_pc=0, queue_count=0, imem_req=0.
  - imem_req is gated by rst, so it is 0 in every cycle rst=0.
  - Reset mid-operation discards the queue and any in-flight response.
- Issue:
  - imem_req = rst & ~redirect & (count + inflight < DEPTH).
  - On issue: fetch_pc<=fetch_pc+1 (wraps), inflight<=1 with tag pc=fetch_pc.
  - Otherwise inflight<=0.
  - At most one request per cycle; sustained throughput is 1 word/cycle when decode is not stalled.
- Response:
  - In the cycle after an issue, imem_rdata is pushed with tag+1 at the edge, unless a redirect occurs in that cycle.
  - Space for the push is guaranteed by the issue rule, so overflow is impossible.
- Output and pop:
  - Head entry is driven from registered storage; first valid word appears 2 cycles after its request cycle.
  - Pop when instr_valid & ~id_stall.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - While id_stall=1 the outputs hold stable.
- Redirect = is_jump | branch_taken. If both are asserted, is_jump wins and the target is jump_addr; otherwise the target is branch_addr.
  - In the redirect cycle: imem_req=0; the response arriving that cycle is discarded.
  - At the edge: queue cleared, fetch_pc<=target, inflight<=0.
  - Next cycle: instr_valid=0 and target is requested.
  - Target word is valid 3 cycles after the redirect cycle.
  - A pop in the redirect cycle is still consumed by decode; it is the decode stage's duty to squash it.
  - Back-to-back redirects: the latest one wins; the earlier target is never pushed.
- Boundaries:
  - fetch_pc 2^PC_WIDTH-1 wraps to 0; next_pc of that entry is 0.
  - Queue pointers wrap modulo DEPTH.
  - Empty: instr_valid=0 regardless of id_stall.
  - Full (count=DEPTH): no issue until a pop; in the pop cycle count+inflight<DEPTH is evaluated on the registered count, so issue resumes the following cycle.

Test Plan:
- Reset release, memory returns word = 0xA000_0000|addr, id_stall=0.
  -> imem_addr sequence 0,1,2,…; instr_valid first high 2 cycles after the first req; instruction 0xA0000000 with next_pc 1, then 0xA0000001 with next_pc 2, one per cycle.
- Hold id_stall=1 from the first valid.
  -> queue_count saturates at 4, imem_req drops to 0, instruction held at 0xA0000000.
  -> Release stall: words 0..4 delivered in order with no loss or duplicate.
- is_jump=1 with jump_addr=0x100 while the queue holds 3 entries and a response is in flight.
  -> next cycle queue_count=0, instr_valid=0, imem_addr=0x100; 3 cycles after the redirect, instruction 0xA0000100 with next_pc 0x101.
- is_jump=1 (jump_addr=0x20) and branch_taken=1 (branch_addr=0x40) in the same cycle.
  -> fetch resumes at 0x20; nothing from 0x40 is ever delivered.
- Jump to 0x3FF with PC_WIDTH=10.
  -> entry 0x3FF has next_pc 0; following fetch is addr 0.
- Assert rst=0 for one edge mid-stream with a full queue.
  -> all outputs 0 next cycle; fetch restarts at RESET_PC; no pre-reset word appears.
